// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional baud-rate tick generator.
// Emits single-cycle enable strobes in the fclk domain:
// an oversample tick, a mid-bit tick and an end-of-bit tick.
// The period is a runtime-loadable integer divisor plus a fractional part.
// The fractional part is spread over ticks by a first-order accumulator,
// so each oversample period is either div or div+1 cycles long.
module uart_baud_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OSR      = 8,
    parameter int DEF_DIV  = 27,
    parameter int DEF_FRAC = 0
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              resync,
    output logic              tick_os,
    output logic              tick_mid,
    output logic              tick_bit,
    output logic              cfg_err
);

    // Width of the oversample counter; a degenerate OSR still gets one bit.
    localparam int SC_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [SC_W-1:0]   SC_MID   = SC_W'(OSR / 2 - 1);
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(OSR - 1);
    localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEF_DIV);
    localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(DEF_FRAC);
    localparam logic [DIV_W:0]    PC_ONE   = (DIV_W + 1)'(1);
    localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);

    // Reject parameter sets the tick arithmetic cannot honour.
    generate
        if (FRAC_W < 1) begin : g_bad_frac
            $error("uart_baud_gen: FRAC_W must be at least 1");
        end
        if ((OSR < 4) || ((OSR % 2) != 0)) begin : g_bad_osr
            $error("uart_baud_gen: OSR must be even and at least 4");
        end
    endgenerate

    // Active configuration.
    logic [DIV_W-1:0]  div_reg,  div_next;
    logic [FRAC_W-1:0] frac_reg, frac_next;

    // Counters: the prescaler is one bit wider than the divisor so that
    // a full-scale divisor plus the extension cycle still fits.
    logic [DIV_W:0]    pc_reg,   pc_next;
    logic [FRAC_W-1:0] acc_reg,  acc_next;
    logic              ext_reg,  ext_next;
    logic [SC_W-1:0]   sc_reg,   sc_next;

    // Registered outputs.
    logic tick_os_reg,  tick_os_next;
    logic tick_mid_reg, tick_mid_next;
    logic tick_bit_reg, tick_bit_next;
    logic cfg_err_reg,  cfg_err_next;

    // Derived per-cycle terms.
    logic [DIV_W:0]  period_len;
    logic            period_end;
    logic [FRAC_W:0] acc_sum;
    logic            div_zero;

    // Current period length, end-of-period detect and fractional sum.
    always_comb begin
        period_len = {1'b0, div_reg} + {{DIV_W{1'b0}}, ext_reg};
        // >= rather than == keeps the prescaler self-recovering.
        period_end = (pc_reg >= (period_len - PC_ONE));
        acc_sum    = {1'b0, acc_reg} + {1'b0, frac_reg};
        div_zero   = (div_reg == '0);
    end

    // Next-state logic: load beats resync, resync beats tick generation.
    always_comb begin
        div_next      = div_reg;
        frac_next     = frac_reg;
        pc_next       = pc_reg;
        acc_next      = acc_reg;
        ext_next      = ext_reg;
        sc_next       = sc_reg;
        tick_os_next  = 1'b0;
        tick_mid_next = 1'b0;
        tick_bit_next = 1'b0;

        if (load) begin
            // New divisor; the period in progress is abandoned.
            div_next  = div_int;
            frac_next = div_frac;
            pc_next   = '0;
            acc_next  = '0;
            ext_next  = 1'b0;
            sc_next   = '0;
        end else if (resync) begin
            // Restart the bit phase, keeping the divisor.
            pc_next  = '0;
            acc_next = '0;
            ext_next = 1'b0;
            sc_next  = '0;
        end else if (en && !div_zero) begin
            if (period_end) begin
                pc_next       = '0;
                tick_os_next  = 1'b1;
                // Carry out of the accumulator stretches the next period.
                acc_next      = acc_sum[FRAC_W-1:0];
                ext_next      = acc_sum[FRAC_W];
                sc_next       = (sc_reg == SC_LAST) ? '0 : (sc_reg + SC_ONE);
                tick_mid_next = (sc_reg == SC_MID);
                tick_bit_next = (sc_reg == SC_LAST);
            end else begin
                pc_next = pc_reg + PC_ONE;
            end
        end

        // Tracks the divisor that will be active after this edge, so the
        // flag never lags the divisor register.
        cfg_err_next = (div_next == '0);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= DIV_RST;
            frac_reg     <= FRAC_RST;
            pc_reg       <= '0;
            acc_reg      <= '0;
            ext_reg      <= 1'b0;
            sc_reg       <= '0;
            tick_os_reg  <= 1'b0;
            tick_mid_reg <= 1'b0;
            tick_bit_reg <= 1'b0;
            cfg_err_reg  <= (DEF_DIV == 0);
        end else begin
            div_reg      <= div_next;
            frac_reg     <= frac_next;
            pc_reg       <= pc_next;
            acc_reg      <= acc_next;
            ext_reg      <= ext_next;
            sc_reg       <= sc_next;
            tick_os_reg  <= tick_os_next;
            tick_mid_reg <= tick_mid_next;
            tick_bit_reg <= tick_bit_next;
            cfg_err_reg  <= cfg_err_next;
        end
    end

    assign tick_os  = tick_os_reg;
    assign tick_mid = tick_mid_reg;
    assign tick_bit = tick_bit_reg;
    assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen: stimulus pushes expected tick edges into a
// scoreboard queue, and a monitor pops and compares on every tick_os.
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 8;

    logic              fclk;
    logic              rst_n;
    logic              en;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              resync;
    logic              tick_os;
    logic              tick_mid;
    logic              tick_bit;
    logic              cfg_err;

    typedef struct {
        int e;
        bit m;
        bit b;
    } tick_t;

    tick_t exp_q[$];
    int    act_q[$];
    int    cyc;
    int    checks;
    int    errors;

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEF_DIV(27), .DEF_FRAC(0)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .en(en), .load(load),
        .div_int(div_int), .div_frac(div_frac), .resync(resync),
        .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
        .cfg_err(cfg_err)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    // Edge counter: at a falling edge cyc equals the number of rising edges.
    initial cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at edge %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compares every presented tick against the scoreboard.
    initial begin
        tick_t x;
        forever begin
            @(negedge fclk);
            if (rst_n === 1'b1) begin
                if (tick_os === 1'b1) begin
                    act_q.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL stray_tick: tick at edge %0d, required none", cyc);
                    end else begin
                        x = exp_q.pop_front();
                        if (x.e != cyc || x.m != tick_mid || x.b != tick_bit) begin
                            errors++;
                            $display("FAIL tick: edge %0d mid %0b bit %0b, required edge %0d mid %0b bit %0b",
                                     cyc, tick_mid, tick_bit, x.e, x.m, x.b);
                        end
                    end
                end else begin
                    checks++;
                    if (tick_mid !== 1'b0 || tick_bit !== 1'b0) begin
                        errors++;
                        $display("FAIL orphan_strobe: edge %0d mid %0b bit %0b, required 0 0",
                                 cyc, tick_mid, tick_bit);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_one(input int e, input bit m, input bit b);
        tick_t x;
        x.e = e;
        x.m = m;
        x.b = b;
        exp_q.push_back(x);
    endtask

    // Expected ticks after a phase restart at edge 'start'; returns last edge.
    task automatic push_ticks(input int start, input int dv, input int fr,
                              input int n, output int last);
        int e;
        int a;
        int x;
        e = start;
        a = 0;
        x = 0;
        for (int k = 1; k <= n; k++) begin
            e = e + dv + x;
            push_one(e, (k % OSR) == OSR / 2, (k % OSR) == 0);
            a = a + fr;
            x = a >> FRAC_W;
            a = a % (1 << FRAC_W);
        end
        last = e;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge fclk);
    endtask

    // Pulse load so that it is sampled by rising edge 'at'.
    task automatic do_load(input int at, input int dv, input int fr);
        wait_until(at - 1);
        load     = 1'b1;
        div_int  = DIV_W'(dv);
        div_frac = FRAC_W'(fr);
        @(negedge fclk);
        load = 1'b0;
    endtask

    initial begin
        int r;
        int e1, e2, e3, e4, e5, e6, e7;
        int l, l2, s, l3, l4, l5, l6, r2;
        int base;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        resync   = 1'b0;
        div_int  = '0;
        div_frac = '0;
        #1 rst_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge fclk);
        chk("reset_tick_os", int'(tick_os), 0);
        chk("reset_tick_mid", int'(tick_mid), 0);
        chk("reset_tick_bit", int'(tick_bit), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);

        // Default divisor 27, 16 ticks = two bits.
        r = cyc;
        push_ticks(r, 27, 0, 16, e1);
        rst_n = 1'b1;
        chk("def_cfg_err", int'(cfg_err), 0);

        // Divisor 10.5: periods 10,10,11,10,11,...
        l = e1 + 2;
        push_ticks(l, 10, 8, 1002, e2);
        do_load(l, 10, 8);
        base = act_q.size();
        wait_until(e2 + 1);
        if (act_q.size() >= base + 1002) begin
            chk("frac_first_period", act_q[base] - l, 10);
            chk("frac_third_period", act_q[base + 2] - act_q[base + 1], 11);
            chk("frac_span_1000", act_q[base + 1001] - act_q[base + 1], 10500);
        end else begin
            chk("frac_tick_count", act_q.size() - base, 1002);
        end

        // Divisor 4, resync mid-period.
        l2 = e2 + 2;
        s  = l2 + 10;
        push_ticks(l2, 4, 0, 2, e3);
        push_ticks(s, 4, 0, 8, e4);
        do_load(l2, 4, 0);
        wait_until(s - 1);
        resync = 1'b1;
        @(negedge fclk);
        resync = 1'b0;

        // Divisor 6, en low for 7 edges mid-period.
        l3 = e4 + 2;
        push_ticks(l3, 6, 0, 2, e5);
        push_one(l3 + 25, 1'b0, 1'b0);
        push_one(l3 + 31, 1'b1, 1'b0);
        push_one(l3 + 37, 1'b0, 1'b0);
        do_load(l3, 6, 0);
        wait_until(l3 + 14);
        en = 1'b0;
        wait_until(l3 + 21);
        en = 1'b1;

        // Divisor 0: configuration error, no strobes.
        l4 = l3 + 39;
        do_load(l4, 0, 0);
        chk("div0_cfg_err", int'(cfg_err), 1);
        wait_until(l4 + 100);
        chk("div0_cfg_err_hold", int'(cfg_err), 1);

        // Divisor 1: tick_os every cycle.
        l5 = l4 + 102;
        push_ticks(l5, 1, 0, 24, e6);
        do_load(l5, 1, 0);
        chk("div1_cfg_err", int'(cfg_err), 0);

        // load + resync together: load wins with divisor 5.
        wait_until(e6);
        l6 = e6 + 1;
        push_ticks(l6, 5, 0, 5, e7);
        load     = 1'b1;
        resync   = 1'b1;
        div_int  = DIV_W'(5);
        div_frac = '0;
        @(negedge fclk);
        load   = 1'b0;
        resync = 1'b0;

        // Asynchronous reset while a strobe is high.
        wait_until(l6 + 29);
        @(posedge fclk);
        #1;
        chk("pre_reset_tick_os", int'(tick_os), 1);
        rst_n = 1'b0;
        #1;
        chk("async_tick_os", int'(tick_os), 0);
        chk("async_tick_mid", int'(tick_mid), 0);
        chk("async_tick_bit", int'(tick_bit), 0);
        chk("async_cfg_err", int'(cfg_err), 0);
        repeat (2) @(negedge fclk);
        r2 = cyc;
        push_ticks(r2, 27, 0, 2, e1);
        rst_n = 1'b1;
        wait_until(e1 + 2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
